// File: rtl/key_sw_io_if.sv
// rtl/key_sw_io_if.sv - processor-side bus for the key/switch I/O block
interface key_sw_io_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] ADDR;
    logic [DBITS-1:0] DIN;
    logic             WE;
    logic [DBITS-1:0] DOUT;
    logic             SEL;
    logic             IRQ;

    modport master (
        output ADDR,
        output DIN,
        output WE,
        input  DOUT,
        input  SEL,
        input  IRQ
    );

    modport slave (
        input  ADDR,
        input  DIN,
        input  WE,
        output DOUT,
        output SEL,
        output IRQ
    );
endinterface

// File: rtl/key_sw_io.sv
// rtl/key_sw_io.sv - debounced pushbutton/switch inputs with memory-mapped data, status and IRQ
module key_sw_io #(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNTBITS         = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    key_sw_io_if.slave  bus
);
    localparam int NB = 14;
    // Keys are active-low, so their idle (reset) level is 1; switches idle at 0.
    localparam logic [NB-1:0]      RST_LEVEL = 14'h000F;
    localparam logic [CNTBITS-1:0] CNT_LAST  = CNTBITS'(DEBOUNCE_CYCLES - 1);

    localparam logic [DBITS-1:0] A_KDATA = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0] A_SDATA = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0] A_KSTAT = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0] A_SSTAT = DBITS'(16'hFFF6);
    localparam logic [DBITS-1:0] UNMAPPED_RD = DBITS'(16'hDEAD);

    logic [NB-1:0]      w_raw;
    logic [NB-1:0]      r_sync1;
    logic [NB-1:0]      r_sync2;
    logic [NB-1:0]      r_db;
    logic [CNTBITS-1:0] r_cnt [NB];
    logic [NB-1:0]      w_load;

    logic [3:0] r_krdy;
    logic [3:0] r_kovr;
    logic       r_srdy;
    logic       r_sovr;

    logic [3:0] w_press;
    logic       w_sw_chg;
    logic       w_sel_kdata;
    logic       w_sel_sdata;
    logic       w_sel_kstat;
    logic       w_sel_sstat;
    logic [3:0] w_clr_krdy;
    logic [3:0] w_clr_kovr;
    logic       w_clr_srdy;
    logic       w_clr_sovr;
    logic       w_unused_din;

    assign w_raw = {SW, KEY};

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NB; i++) begin
            w_load[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= RST_LEVEL;
            r_sync2 <= RST_LEVEL;
            r_db    <= RST_LEVEL;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_load[i]) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a debounced key bit loading a 0; every switch load is a change.
    assign w_press  = w_load[3:0] & ~r_sync2[3:0];
    assign w_sw_chg = |w_load[NB-1:4];

    assign w_sel_kdata = (bus.ADDR == A_KDATA);
    assign w_sel_sdata = (bus.ADDR == A_SDATA);
    assign w_sel_kstat = (bus.ADDR == A_KSTAT);
    assign w_sel_sstat = (bus.ADDR == A_SSTAT);

    assign w_clr_krdy = (bus.WE && w_sel_kstat) ? bus.DIN[3:0] : 4'h0;
    assign w_clr_kovr = (bus.WE && w_sel_kstat) ? bus.DIN[7:4] : 4'h0;
    assign w_clr_srdy = bus.WE && w_sel_sstat && bus.DIN[0];
    assign w_clr_sovr = bus.WE && w_sel_sstat && bus.DIN[1];
    assign w_unused_din = &{1'b0, bus.DIN};

    // Set wins over a same-edge clear, and a ready flag being cleared on the
    // edge of a new event does not count as an overrun.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_krdy <= 4'h0;
            r_kovr <= 4'h0;
            r_srdy <= 1'b0;
            r_sovr <= 1'b0;
        end else begin
            r_krdy <= (r_krdy & ~w_clr_krdy) | w_press;
            r_kovr <= (r_kovr & ~w_clr_kovr) | (w_press & r_krdy & ~w_clr_krdy);
            r_srdy <= (r_srdy & ~w_clr_srdy) | w_sw_chg;
            r_sovr <= (r_sovr & ~w_clr_sovr) | (w_sw_chg & r_srdy & ~w_clr_srdy);
        end
    end

    always_comb begin
        bus.DOUT = UNMAPPED_RD;
        if (w_sel_kdata) begin
            bus.DOUT = DBITS'(r_db[3:0]);
        end else if (w_sel_sdata) begin
            bus.DOUT = DBITS'(r_db[NB-1:4]);
        end else if (w_sel_kstat) begin
            bus.DOUT = DBITS'({r_kovr, r_krdy});
        end else if (w_sel_sstat) begin
            bus.DOUT = DBITS'({r_sovr, r_srdy});
        end
    end

    assign bus.SEL = w_sel_kdata | w_sel_sdata | w_sel_kstat | w_sel_sstat;
    assign bus.IRQ = (|r_krdy) | r_srdy;
endmodule

// File: tb/tb_key_sw_io.sv
// tb/tb_key_sw_io.sv - directed-vector bench for key_sw_io with DEBOUNCE_CYCLES=4
module tb_key_sw_io;
    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [9:0] sw;
    int         n_tests;
    int         n_fail;
    logic [15:0] rdata;

    key_sw_io_if #(.DBITS(16)) bus_if ();

    key_sw_io #(
        .DBITS          (16),
        .DEBOUNCE_CYCLES(4),
        .CNTBITS        (16)
    ) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .KEY    (key),
        .SW     (sw),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus_if.ADDR = a;
        #1;
        d = bus_if.DOUT;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus_if.ADDR = a;
        bus_if.DIN  = d;
        bus_if.WE   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.WE   = 1'b0;
        bus_if.DIN  = 16'h0000;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b1;
        key = 4'hF;
        sw  = 10'h000;
        bus_if.ADDR = 16'h0000;
        bus_if.DIN  = 16'h0000;
        bus_if.WE   = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state
        cyc(2);
        rd(16'hFFF0, rdata); chk("rst_kdata", rdata, 16'h000F);
        rd(16'hFFF2, rdata); chk("rst_sdata", rdata, 16'h0000);
        rd(16'hFFF4, rdata); chk("rst_kstat", rdata, 16'h0000);
        rd(16'hFFF6, rdata); chk("rst_sstat", rdata, 16'h0000);
        chk("rst_irq", bus_if.IRQ, 1'b0);
        rst_n = 1'b1;
        cyc(3);

        // KEY[1] press: visible exactly 6 edges after the change
        key = 4'hD;
        for (int e = 1; e <= 6; e++) begin
            cyc(1);
            rd(16'hFFF0, rdata); chk($sformatf("k1_kdata_e%0d", e), rdata, (e < 6) ? 16'h000F : 16'h000D);
            rd(16'hFFF4, rdata); chk($sformatf("k1_kstat_e%0d", e), rdata, (e < 6) ? 16'h0000 : 16'h0002);
            chk($sformatf("k1_irq_e%0d", e), bus_if.IRQ, (e < 6) ? 1'b0 : 1'b1);
        end
        key = 4'hF;
        cyc(8);
        rd(16'hFFF4, rdata); chk("k1_release_kstat", rdata, 16'h0002);
        wr(16'hFFF4, 16'h0002);
        rd(16'hFFF4, rdata); chk("k1_clr_kstat", rdata, 16'h0000);
        chk("k1_clr_irq", bus_if.IRQ, 1'b0);

        // SW[3] glitch of 3 cycles is rejected
        sw = 10'h008;
        cyc(3);
        sw = 10'h000;
        for (int e = 1; e <= 10; e++) begin
            cyc(1);
            chk($sformatf("glitch_irq_e%0d", e), bus_if.IRQ, 1'b0);
        end
        rd(16'hFFF2, rdata); chk("glitch_sdata", rdata, 16'h0000);
        rd(16'hFFF6, rdata); chk("glitch_sstat", rdata, 16'h0000);

        // KEY[0] press, release, press -> ready + overrun
        key = 4'hE; cyc(8);
        key = 4'hF; cyc(8);
        key = 4'hE; cyc(8);
        rd(16'hFFF4, rdata); chk("k0_ovr_kstat", rdata, 16'h0011);
        key = 4'hF; cyc(8);
        rd(16'hFFF0, rdata); chk("k0_rel_kdata", rdata, 16'h000F);
        wr(16'hFFF4, 16'h0011);
        rd(16'hFFF4, rdata); chk("k0_clr_kstat", rdata, 16'h0000);
        chk("k0_clr_irq", bus_if.IRQ, 1'b0);

        // Switch change sets SSTAT[0]
        sw = 10'h001; cyc(8);
        rd(16'hFFF2, rdata); chk("sw0_sdata", rdata, 16'h0001);
        rd(16'hFFF6, rdata); chk("sw0_sstat", rdata, 16'h0001);
        chk("sw0_irq", bus_if.IRQ, 1'b1);

        // W1C of SSTAT[0] on the same edge as the next change: set wins, no overrun
        sw = 10'h000;
        cyc(5);
        rd(16'hFFF2, rdata); chk("sw_w1c_pre_sdata", rdata, 16'h0001);
        wr(16'hFFF6, 16'h0001);
        rd(16'hFFF2, rdata); chk("sw_w1c_sdata", rdata, 16'h0000);
        rd(16'hFFF6, rdata); chk("sw_w1c_sstat", rdata, 16'h0001);
        wr(16'hFFF6, 16'h0001);
        rd(16'hFFF6, rdata); chk("sw_clr_sstat", rdata, 16'h0000);

        // Two changes without clearing -> switch overrun
        sw = 10'h002; cyc(8);
        sw = 10'h000; cyc(8);
        rd(16'hFFF6, rdata); chk("sw_ovr_sstat", rdata, 16'h0003);
        wr(16'hFFF6, 16'h0002);
        rd(16'hFFF6, rdata); chk("sw_ovr_partial_clr", rdata, 16'h0001);
        wr(16'hFFF6, 16'h0001);
        chk("sw_clr_irq", bus_if.IRQ, 1'b0);

        // Unmapped read, SEL decode, write to read-only data
        rd(16'hFFF8, rdata); chk("unmapped_dout", rdata, 16'hDEAD);
        chk("unmapped_sel", bus_if.SEL, 1'b0);
        rd(16'hFFF2, rdata); chk("sdata_sel", bus_if.SEL, 1'b1);
        wr(16'hFFF0, 16'hFFFF);
        rd(16'hFFF0, rdata); chk("kdata_ro", rdata, 16'h000F);
        chk("kdata_sel", bus_if.SEL, 1'b1);

        // Reset mid-debounce of KEY[2], then full latency from count 0
        key = 4'hB;
        cyc(4);
        rst_n = 1'b0;
        #1;
        rd(16'hFFF0, rdata); chk("midrst_kdata", rdata, 16'h000F);
        cyc(1);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            cyc(1);
            rd(16'hFFF4, rdata); chk($sformatf("k2_kstat_e%0d", e), rdata, (e < 6) ? 16'h0000 : 16'h0004);
        end
        rd(16'hFFF0, rdata); chk("k2_kdata", rdata, 16'h000B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_sw_io.md
KEY_SW_IO -- requirements
Module: key_sw_io

Interface
REQ-001 SHALL have parameter DBITS, default 16, bus data width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, number of stable synchronized cycles needed to accept an input change.
REQ-003 SHALL have parameter CNTBITS, default 16, debounce counter width; DEBOUNCE_CYCLES SHALL fit in CNTBITS.
REQ-004 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port KEY  input  4  raw pushbuttons, asynchronous, active-low (0 = pressed).
REQ-007 SHALL have port SW  input  10  raw slide switches, asynchronous.
REQ-008 SHALL have port ADDR  input  DBITS  byte address from the processor MAR.
REQ-009 SHALL have port DIN  input  DBITS  write data from the processor bus.
REQ-010 SHALL have port WE  input  1  write strobe, sampled on rising CLK.
REQ-011 SHALL have port DOUT  output  DBITS  read data, combinational from ADDR and state.
REQ-012 SHALL have port SEL  output  1  high when ADDR is one of the four mapped addresses.
REQ-013 SHALL have port IRQ  output  1  level request, OR of all ready flags.

Function
REQ-014 SHALL pass each KEY and SW bit through a two-flop synchronizer before any other use.
REQ-015 SHALL keep one CNTBITS counter per input bit (14 total); the counter increments each cycle the synchronized bit differs from its debounced bit and clears to 0 on any cycle where they are equal.
REQ-016 SHALL, on the edge where a counter equals DEBOUNCE_CYCLES-1 and the bits still differ, load the debounced bit from the synchronized bit and clear the counter.
REQ-017 Latency: a raw change held stable SHALL appear in the debounced value exactly 2+DEBOUNCE_CYCLES rising edges later; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach the debounced value.
REQ-018 SHALL decode address map: 0xFFF0 KDATA, 0xFFF2 SDATA, 0xFFF4 KSTAT, 0xFFF6 SSTAT; all reads zero-extended to DBITS.
REQ-019 KDATA SHALL read the debounced KEY value, not inverted.
REQ-020 SDATA SHALL read the debounced SW value.
REQ-021 KSTAT[3:0] SHALL be per-key ready flags, set on the edge where that key's debounced bit goes 1->0 (press); releases set nothing.
REQ-022 KSTAT[7:4] SHALL be per-key overrun flags, set when a press occurs while that key's ready flag is already 1.
REQ-023 SSTAT[0] SHALL be the switch-change ready flag, set when any debounced SW bit changes in either direction.
REQ-024 SSTAT[1] SHALL be the switch overrun flag, set when a change occurs while SSTAT[0] is already 1.
REQ-025 Writes with WE=1 to KSTAT or SSTAT SHALL be write-1-to-clear on the corresponding flag bits; 0 bits SHALL leave flags unchanged.
REQ-026 Writes to KDATA, SDATA or unmapped addresses SHALL have no effect.
REQ-027 Simultaneous set event and W1C of the same ready flag SHALL leave the flag set and SHALL NOT set overrun.
REQ-028 Simultaneous set event and W1C of the same overrun flag SHALL leave the overrun flag set.
REQ-029 Multiple keys pressed on the same edge SHALL each set their own flags independently.
REQ-030 For an unmapped ADDR, DOUT SHALL be 16'hDEAD and SEL SHALL be 0.
REQ-031 IRQ SHALL equal |KSTAT[3:0] | SSTAT[0], registered-state derived with no extra delay.

Reset
REQ-032 On RESET_N low, SHALL asynchronously force: KEY synchronizers and debounced KEY to 4'hF, SW synchronizers and debounced SW to 10'h000, all counters to 0, all flags to 0.
REQ-033 Outputs during reset: KDATA read 16'h000F, SDATA read 16'h0000, KSTAT/SSTAT read 0, IRQ 0.
REQ-034 Reset asserted mid-debounce SHALL discard the count; after release, a change already present on an input SHALL be debounced from count 0 and SHALL raise the normal event (e.g. SW nonzero at release sets SSTAT[0]).

Verification (DEBOUNCE_CYCLES=4)
REQ-035 KEY[1] driven 1->0 and held -> KDATA=16'h000D and KSTAT=16'h0002, IRQ=1, exactly 6 edges after the change; none earlier.
REQ-036 SW[3] pulsed high for 3 cycles then low -> SDATA stays 0, SSTAT stays 0, IRQ stays 0.
REQ-037 KEY[0] pressed, released, pressed again without clearing -> KSTAT=16'h0011; write 16'h0011 to 0xFFF4 -> KSTAT=0, IRQ=0.
REQ-038 W1C write of 16'h0001 to 0xFFF6 on the same edge SW debounced value changes -> SSTAT[0]=1, SSTAT[1]=0.
REQ-039 Read 0xFFF8 -> DOUT=16'hDEAD, SEL=0; write 16'hFFFF to 0xFFF0 -> KDATA unchanged.
REQ-040 RESET_N pulsed low at count 2 of a KEY[2] press -> KDATA=16'h000F immediately; after release, with KEY[2] still held, KSTAT[2] sets 6 edges later.
